// File: rtl/eth_cmd_regs_mch.sv
// Multi-channel Ethernet/IP/UDP/ARP header register file: shadow/active profiles
// per channel, queued send requests and a round-robin valid/ready request port.
module eth_cmd_regs_mch #(
    parameter int          NUM_CH      = 4,
    parameter logic [15:0] UDP_LEN_DEF = 16'd0,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_cmd_addr,
    input  logic [31:0]       i_cmd_data,
    input  logic              i_cmd_wr,
    input  logic              i_cmd_rd,
    output logic [31:0]       o_rd_data,
    output logic              o_rd_valid,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [CH_W-1:0]   o_req_ch,
    output logic [1:0]        o_req_type,
    output logic [47:0]       o_dst_mac,
    output logic [47:0]       o_src_mac,
    output logic [47:0]       o_SHA,
    output logic [47:0]       o_THA,
    output logic [31:0]       o_src_ip,
    output logic [31:0]       o_dst_ip,
    output logic [31:0]       o_SPA,
    output logic [31:0]       o_TPA,
    output logic [15:0]       o_src_port,
    output logic [15:0]       o_dst_port,
    output logic [15:0]       o_udp_data_len,
    output logic [1:0]        o_operation,
    output logic [NUM_CH-1:0] o_overrun
);

    localparam logic [7:0] A_SEND = 8'd2,  A_COMMIT = 8'd4,  A_CHSEL = 8'd8,  A_STATUS = 8'd12;
    localparam logic [7:0] A_SMAC_H = 8'd24, A_SMAC_L = 8'd28, A_DMAC_H = 8'd32, A_DMAC_L = 8'd36;
    localparam logic [7:0] A_SIP = 8'd40, A_DIP = 8'd44, A_SPORT = 8'd48, A_DPORT = 8'd52;
    localparam logic [7:0] A_ULEN = 8'd60, A_OP = 8'd64, A_THA_H = 8'd68, A_THA_L = 8'd72;
    localparam logic [7:0] A_TPA = 8'd76, A_SHA_H = 8'd80, A_SHA_L = 8'd84, A_SPA = 8'd88;

    typedef struct packed {
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
        logic [47:0] tha;
        logic [47:0] sha;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [31:0] tpa;
        logic [31:0] spa;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_len;
        logic [1:0]  op;
    } prof_t;

    function automatic prof_t prof_rst();
        prof_t p;
        p         = '0;
        p.udp_len = UDP_LEN_DEF;
        return p;
    endfunction

    prof_t             shadow [NUM_CH];
    prof_t             active [NUM_CH];
    logic [1:0]        req_type_q [NUM_CH];
    logic [CH_W-1:0]   ch_sel, rr, grant, rr_next;
    logic [NUM_CH-1:0] pending, overrun, commit_pend;
    logic [NUM_CH-1:0] pres, acc, send_set, commit_set, copy, ovr_set, ovr_clr, cand;
    logic              wr_send, wr_commit, wr_chsel, wr_status, xfer, found;
    logic [31:0]       rd_mux;
    prof_t             sh;

    assign wr_send   = i_cmd_wr && (i_cmd_addr == A_SEND);
    assign wr_commit = i_cmd_wr && (i_cmd_addr == A_COMMIT);
    assign wr_chsel  = i_cmd_wr && (i_cmd_addr == A_CHSEL);
    assign wr_status = i_cmd_wr && (i_cmd_addr == A_STATUS);
    assign xfer      = o_req_valid && i_req_ready;
    assign ovr_clr   = wr_status ? i_cmd_data[8 +: NUM_CH] : '0;
    assign cand      = pending & ~acc;

    // A presented, not-yet-accepted channel defers its commit to the acceptance edge
    always_comb begin
        pres       = '0;
        acc        = '0;
        send_set   = '0;
        commit_set = '0;
        copy       = '0;
        ovr_set    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pres[c]       = o_req_valid && (o_req_ch == CH_W'(c));
            acc[c]        = pres[c] && i_req_ready;
            send_set[c]   = wr_send && (i_cmd_data[1:0] != 2'd0) && i_cmd_data[8+c];
            commit_set[c] = wr_commit && i_cmd_data[c];
            copy[c]       = (commit_set[c] && !(pres[c] && !acc[c])) || (acc[c] && commit_pend[c]);
            ovr_set[c]    = send_set[c] && pending[c] && !acc[c];
        end
    end

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int idx;
            idx = int'(rr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && cand[CH_W'(idx)]) begin
                found = 1'b1;
                grant = CH_W'(idx);
            end
        end
        rr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) shadow[c] <= prof_rst();
        end else if (i_cmd_wr) begin
            case (i_cmd_addr)
                A_SMAC_H: shadow[ch_sel].src_mac[47:16] <= i_cmd_data;
                A_SMAC_L: shadow[ch_sel].src_mac[15:0]  <= i_cmd_data[15:0];
                A_DMAC_H: shadow[ch_sel].dst_mac[47:16] <= i_cmd_data;
                A_DMAC_L: shadow[ch_sel].dst_mac[15:0]  <= i_cmd_data[15:0];
                A_SIP:    shadow[ch_sel].src_ip         <= i_cmd_data;
                A_DIP:    shadow[ch_sel].dst_ip         <= i_cmd_data;
                A_SPORT:  shadow[ch_sel].src_port       <= i_cmd_data[15:0];
                A_DPORT:  shadow[ch_sel].dst_port       <= i_cmd_data[15:0];
                A_ULEN:   shadow[ch_sel].udp_len        <= i_cmd_data[15:0];
                A_OP:     shadow[ch_sel].op             <= i_cmd_data[1:0];
                A_THA_H:  shadow[ch_sel].tha[47:16]     <= i_cmd_data;
                A_THA_L:  shadow[ch_sel].tha[15:0]      <= i_cmd_data[15:0];
                A_TPA:    shadow[ch_sel].tpa            <= i_cmd_data;
                A_SHA_H:  shadow[ch_sel].sha[47:16]     <= i_cmd_data;
                A_SHA_L:  shadow[ch_sel].sha[15:0]      <= i_cmd_data[15:0];
                A_SPA:    shadow[ch_sel].spa            <= i_cmd_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) active[c] <= prof_rst();
        end else begin
            for (int c = 0; c < NUM_CH; c++) if (copy[c]) active[c] <= shadow[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_sel      <= '0;
            pending     <= '0;
            overrun     <= '0;
            commit_pend <= '0;
            for (int c = 0; c < NUM_CH; c++) req_type_q[c] <= 2'd0;
        end else begin
            if (wr_chsel && (i_cmd_data < 32'(NUM_CH))) ch_sel <= i_cmd_data[CH_W-1:0];
            overrun <= (overrun & ~ovr_clr) | ovr_set;
            for (int c = 0; c < NUM_CH; c++) begin
                if (send_set[c] && (!pending[c] || acc[c])) begin
                    pending[c]    <= 1'b1;
                    req_type_q[c] <= i_cmd_data[1:0];
                end else if (acc[c]) begin
                    pending[c] <= 1'b0;
                end
                if (acc[c]) commit_pend[c] <= 1'b0;
                else if (commit_set[c] && pres[c]) commit_pend[c] <= 1'b1;
            end
        end
    end

    // Request register reloads whenever it is empty or being emptied this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_req_valid <= 1'b0;
            o_req_ch    <= '0;
            o_req_type  <= 2'd0;
            rr          <= '0;
        end else if (!o_req_valid || xfer) begin
            if (found) begin
                o_req_valid <= 1'b1;
                o_req_ch    <= grant;
                o_req_type  <= req_type_q[grant];
                rr          <= rr_next;
            end else begin
                o_req_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        sh     = shadow[ch_sel];
        rd_mux = '0;
        case (i_cmd_addr)
            A_CHSEL:  rd_mux = 32'(ch_sel);
            A_STATUS: begin
                rd_mux[16 +: NUM_CH] = commit_pend;
                rd_mux[8 +: NUM_CH]  = overrun;
                rd_mux[0 +: NUM_CH]  = pending;
            end
            A_SMAC_H: rd_mux = sh.src_mac[47:16];
            A_SMAC_L: rd_mux = {16'd0, sh.src_mac[15:0]};
            A_DMAC_H: rd_mux = sh.dst_mac[47:16];
            A_DMAC_L: rd_mux = {16'd0, sh.dst_mac[15:0]};
            A_SIP:    rd_mux = sh.src_ip;
            A_DIP:    rd_mux = sh.dst_ip;
            A_SPORT:  rd_mux = {16'd0, sh.src_port};
            A_DPORT:  rd_mux = {16'd0, sh.dst_port};
            A_ULEN:   rd_mux = {16'd0, sh.udp_len};
            A_OP:     rd_mux = {30'd0, sh.op};
            A_THA_H:  rd_mux = sh.tha[47:16];
            A_THA_L:  rd_mux = {16'd0, sh.tha[15:0]};
            A_TPA:    rd_mux = sh.tpa;
            A_SHA_H:  rd_mux = sh.sha[47:16];
            A_SHA_L:  rd_mux = {16'd0, sh.sha[15:0]};
            A_SPA:    rd_mux = sh.spa;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_cmd_rd && !i_cmd_wr;
            if (i_cmd_rd && !i_cmd_wr) o_rd_data <= rd_mux;
        end
    end

    assign o_dst_mac      = active[o_req_ch].dst_mac;
    assign o_src_mac      = active[o_req_ch].src_mac;
    assign o_SHA          = active[o_req_ch].sha;
    assign o_THA          = active[o_req_ch].tha;
    assign o_src_ip       = active[o_req_ch].src_ip;
    assign o_dst_ip       = active[o_req_ch].dst_ip;
    assign o_SPA          = active[o_req_ch].spa;
    assign o_TPA          = active[o_req_ch].tpa;
    assign o_src_port     = active[o_req_ch].src_port;
    assign o_dst_port     = active[o_req_ch].dst_port;
    assign o_udp_data_len = active[o_req_ch].udp_len;
    assign o_operation    = active[o_req_ch].op;
    assign o_overrun      = overrun;

endmodule

// File: tb/tb_eth_cmd_regs_mch.sv
// Directed bench for eth_cmd_regs_mch: request and readback scoreboards checked
// with immediate assertions.
module tb_eth_cmd_regs_mch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic        i_cmd_wr, i_cmd_rd, i_req_ready;
    logic [31:0] o_rd_data;
    logic        o_rd_valid, o_req_valid;
    logic [1:0]  o_req_ch, o_req_type, o_operation;
    logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
    logic [31:0] o_src_ip, o_dst_ip, o_SPA, o_TPA;
    logic [15:0] o_src_port, o_dst_port, o_udp_data_len;
    logic [3:0]  o_overrun;

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] typ;
    } req_t;

    req_t        sb [$];
    logic [31:0] rd_q [$];
    int          total = 0;
    int          bad = 0;

    eth_cmd_regs_mch #(.NUM_CH(4), .UDP_LEN_DEF(16'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
        .i_cmd_wr(i_cmd_wr), .i_cmd_rd(i_cmd_rd),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
        .o_req_ch(o_req_ch), .o_req_type(o_req_type),
        .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_SHA(o_SHA), .o_THA(o_THA),
        .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip), .o_SPA(o_SPA), .o_TPA(o_TPA),
        .o_src_port(o_src_port), .o_dst_port(o_dst_port),
        .o_udp_data_len(o_udp_data_len), .o_operation(o_operation),
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        i_cmd_addr = a;
        i_cmd_data = d;
        i_cmd_wr   = 1'b1;
        tick();
        i_cmd_wr   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        rd_q.push_back(exp);
        i_cmd_addr = a;
        i_cmd_rd   = 1'b1;
        tick();
        i_cmd_rd   = 1'b0;
        check({tag, "_vld"}, o_rd_valid, 1);
        check(tag, o_rd_data, rd_q.pop_front());
    endtask

    task automatic send(input logic [31:0] d);
        for (int c = 0; c < 4; c++)
            if (d[1:0] != 2'd0 && d[8+c]) sb.push_back('{ch: 2'(c), typ: d[1:0]});
        wr(8'd2, d);
    endtask

    // Pops the expected request, compares it with the presented one, then transfers it
    task automatic take(input string tag, input bit hold);
        req_t e;
        e = '1;
        check({tag, "_sbq"}, sb.size() > 0, 1);
        if (sb.size() > 0) e = sb.pop_front();
        check({tag, "_vld"}, o_req_valid, 1);
        check({tag, "_ch"}, o_req_ch, e.ch);
        check({tag, "_type"}, o_req_type, e.typ);
        i_req_ready = 1'b1;
        tick();
        if (!hold) i_req_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        i_cmd_addr = '0;
        i_cmd_data = '0;
        i_cmd_wr = 1'b0;
        i_cmd_rd = 1'b0;
        i_req_ready = 1'b0;
        repeat (3) tick();
        check("rst_req_valid", o_req_valid, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_req_ch", o_req_ch, 0);
        check("rst_req_type", o_req_type, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_udp_len", o_udp_data_len, 0);
        rst_n = 1'b1;
        tick();

        // Program channel 1 and send it
        wr(8'd8, 32'd1);
        wr(8'd40, 32'hC0A8_0001);
        wr(8'd24, 32'h0011_2233);
        wr(8'd28, 32'h0000_4455);
        wr(8'd4, 32'h2);
        send(32'h0201);
        check("t1_valid_e0", o_req_valid, 0);
        tick();
        check("t1_src_ip", o_src_ip, 32'hC0A8_0001);
        check("t1_src_mac", o_src_mac, 48'h0011_2233_4455);
        take("t1", 0);
        check("t1_valid_after", o_req_valid, 0);
        rd(8'd12, 32'h0, "t1_status");

        // Four channels pending, round-robin drain with ready held high
        do_reset();
        send(32'h0F03);
        repeat (10) tick();
        rd(8'd12, 32'h0000_000F, "t2_pend_f");
        for (int k = 0; k < 4; k++) take($sformatf("t2_grant%0d", k), 1);
        i_req_ready = 1'b0;
        check("t2_valid_after", o_req_valid, 0);
        rd(8'd12, 32'h0, "t2_pend_0");

        // Overrun on a second SEND while pending
        do_reset();
        send(32'h0401);
        wr(8'd2, 32'h0402);
        rd(8'd12, 32'h0000_0404, "t3_status_ovr");
        check("t3_overrun", o_overrun, 4'b0100);
        wr(8'd12, 32'h0400);
        rd(8'd12, 32'h0000_0004, "t3_status_clr");
        check("t3_overrun_clr", o_overrun, 0);
        take("t3", 0);

        // Commit deferred while channel 0 is presented
        do_reset();
        send(32'h0101);
        tick();
        wr(8'd60, 32'd100);
        wr(8'd4, 32'h1);
        check("t4_len_frozen", o_udp_data_len, 0);
        rd(8'd12, 32'h0001_0001, "t4_commit_pend");
        take("t4", 0);
        check("t4_len_after", o_udp_data_len, 100);
        rd(8'd12, 32'h0, "t4_status_after");

        // Readback latency, ch_sel range and unmapped addresses
        wr(8'd8, 32'd3);
        wr(8'd60, 32'h1234);
        rd(8'd60, 32'h0000_1234, "t5_rd_len");
        tick();
        check("t5_rd_valid_drop", o_rd_valid, 0);
        wr(8'd8, 32'd7);
        rd(8'd8, 32'd3, "t5_chsel");
        rd(8'h10, 32'h0, "t5_unmapped");
        rd(8'd2, 32'h0, "t5_send_rd");

        // Asynchronous reset mid-handshake
        wr(8'd4, 32'h8);
        wr(8'd2, 32'h0801);
        tick();
        check("t6_valid_pre", o_req_valid, 1);
        check("t6_ch_pre", o_req_ch, 3);
        check("t6_len_pre", o_udp_data_len, 16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_rst", o_req_valid, 0);
        check("t6_ch_rst", o_req_ch, 0);
        check("t6_len_rst", o_udp_data_len, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        rd(8'd12, 32'h0, "t6_status");
        rd(8'd8, 32'h0, "t6_chsel");
        wr(8'd8, 32'd3);
        rd(8'd60, 32'h0, "t6_shadow_len");
        check("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_cmd_regs_mch.md
Name: eth_cmd_regs_mch

Overview:
- Multi-channel successor to the single-profile packet command register file.
- Holds NUM_CH independent Ethernet/IP/UDP/ARP header profiles, each with a shadow copy and an active copy; the active copy is updated by an explicit commit.
- Queues per-channel send requests and arbitrates them round-robin to the packet generator over a valid/ready handshake.
- Provides one-cycle-latency register readback and status.

Parameters:
- NUM_CH, 4, number of header profiles/channels (1..8); CH_W = max(1, clog2(NUM_CH)).
- UDP_LEN_DEF, 16'd0, reset value of every channel's udp_data_len (shadow and active).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_cmd_addr  in  8  byte address of register access
- i_cmd_data  in  32  write data
- i_cmd_wr  in  1  write strobe, one access per cycle
- i_cmd_rd  in  1  read strobe; ignored when i_cmd_wr is high
- o_rd_data  out  32  readback data
- o_rd_valid  out  1  o_rd_data valid, exactly one cycle after i_cmd_rd
- o_req_valid  out  1  send request presented to generator
- i_req_ready  in  1  generator accepts; transfer when o_req_valid && i_req_ready
- o_req_ch  out  CH_W  channel of presented request
- o_req_type  out  2  packet type of presented request (1..3)
- o_dst_mac, o_src_mac, o_SHA, o_THA  out  48 each  active fields of o_req_ch
- o_src_ip, o_dst_ip, o_SPA, o_TPA  out  32 each  active fields of o_req_ch
- o_src_port, o_dst_port, o_udp_data_len  out  16 each  active fields of o_req_ch
- o_operation  out  2  active arp_operation of o_req_ch
- o_overrun  out  NUM_CH  sticky per-channel overrun flags

Behaviour:
- Reset (asynchronous): all shadow/active fields 0 except udp_data_len = UDP_LEN_DEF. ch_sel, pending, presented, overrun, commit_pend, rr pointer, o_req_valid, o_rd_valid = 0. o_req_ch = 0, o_req_type = 0, o_rd_data = 0. Reset mid-handshake drops the request without completion.
- Address map (writes on i_cmd_wr):
  - 2 SEND: type = data[1:0], mask = data[8+NUM_CH-1:8]; type 0 is a no-op.
  - 4 COMMIT: mask = data[NUM_CH-1:0].
  - 8 CH_SEL: data[CH_W-1:0]; values >= NUM_CH are ignored and the old value is kept.
  - 12 STATUS: write-1-to-clear overrun = data[8+NUM_CH-1:8].
  - Field registers, written into the shadow copy of ch_sel; upper halves take data[31:0], lower halves take data[15:0], arp_operation takes data[1:0]:
    - 24/28 src_mac [47:16]/[15:0]; 32/36 dst_mac [47:16]/[15:0]
    - 40 src_ip; 44 dst_ip; 48 src_port; 52 dst_port; 60 udp_data_len; 64 arp_operation
    - 68/72 THA [47:16]/[15:0]; 76 TPA
    - 80/84 SHA [47:16]/[15:0]; 88 SPA
  - Unlisted addresses: writes ignored, reads return 0.
- Readback:
  - Field addresses return the shadow copy of ch_sel, zero-extended.
  - 8 returns ch_sel.
  - 12 returns {commit_pend at [16+:NUM_CH], overrun at [8+:NUM_CH], pending at [0+:NUM_CH]}.
  - SEND and COMMIT read 0.
  - Data is registered: i_cmd_rd sampled at edge E gives o_rd_valid=1 and o_rd_data after E, for 1 cycle.
- SEND, per masked channel c:
  - If pending[c]=0: set pending[c], store type[c].
  - If pending[c]=1 and c is not accepted in the same cycle: drop the request, set overrun[c], leave type[c] unchanged.
  - If c is accepted in the same cycle: the new SEND re-pends c with no overrun.
- COMMIT, per masked channel c:
  - If c is presented (o_req_valid && o_req_ch==c) and not accepted this cycle: set commit_pend[c]. Active fields stay frozen while presented.
  - Otherwise copy shadow to active at that edge.
  - On acceptance of c with commit_pend[c]=1: copy shadow to active at the acceptance edge and clear commit_pend[c].
- Arbiter/request register:
  - When o_req_valid=0, or when a transfer occurs this cycle, choose the next pending channel, excluding the one just accepted. Search starts at rr pointer; rr pointer becomes the granted channel + 1 mod NUM_CH.
  - Load o_req_ch and o_req_type, set o_req_valid.
  - Latency: SEND sampled at edge E0 sets pending after E0; o_req_valid rises after E1.
  - Back-to-back grants with no bubble when i_req_ready is held high and other channels are pending.
- Handshake:
  - o_req_valid, o_req_ch, o_req_type and all header outputs are stable until transfer.
  - Transfer clears pending[o_req_ch].
  - o_req_valid never drops without a transfer, except on reset.
- Same-cycle SEND and COMMIT on one channel: the commit applies at that edge, so the request carries the new values.

Test Plan:
- CH_SEL=1; write 40=0xC0A80001, 24=0x00112233, 28=0x4455; COMMIT 0x2; SEND 0x0201 -> o_req_valid after 2 edges, o_req_ch=1, o_req_type=1, o_src_ip=0xC0A80001, o_src_mac=0x001122334455.
- SEND 0x0F03 with i_req_ready=0 for 10 cycles, then 1 -> grants in order ch0,1,2,3 on consecutive cycles; pending reads 0xF then 0x0.
- SEND ch2 twice while pending -> overrun[2]=1, STATUS reads 0x0404; write 12=0x0400 -> overrun clears; type stays the first value.
- Ch0 presented, i_req_ready=0; change shadow udp_data_len to 100, COMMIT 0x1 -> o_udp_data_len unchanged, commit_pend[0]=1; after acceptance the active value is 100 and commit_pend clears.
- Read 60 after writing 60=0x1234 to ch3 -> o_rd_valid one cycle later, o_rd_data=0x00001234; CH_SEL=7 with NUM_CH=4 -> ch_sel stays 3.
- Assert rst_n=0 while o_req_valid=1 -> o_req_valid=0, pending=0 and all fields default immediately.
